mips32_mem_arbiter: RTL and testbench
=====================================

Name: mips32_mem_arbiter

Overview:
- Shares the single-port 1024x32 unified memory between three requesters: instruction fetch (IF), data load/store (DM, MEM stage) and host/debug loader (HP).
- Issues one memory access per cycle and returns read data one cycle later to the owner.
- Sequences run, drain and host-access modes so program images can be loaded and inspected with the core frozen.

Parameters:
- AW, 10, word address width (1024 words).
- DW, 32, data width.
- STARVE_MAX, 4, consecutive IF denials before IF is promoted above DM.

Ports:
- clk1  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- if_req  input  1  fetch read request.
- if_addr  input  AW  fetch word address.
- if_gnt  output  1  fetch granted this cycle (combinational).
- if_rvalid  output  1  fetch read data valid (registered).
- if_rdata  output  DW  fetch read data.
- dm_req  input  1  data access request.
- dm_we  input  1  1 = store, 0 = load.
- dm_addr  input  AW  data word address.
- dm_wdata  input  DW  store data.
- dm_gnt  output  1  data access granted this cycle.
- dm_rvalid  output  1  load data valid.
- dm_rdata  output  DW  load data.
- hp_req  input  1  host request.
- hp_we  input  1  host write enable.
- hp_addr  input  AW  host word address.
- hp_wdata  input  DW  host write data.
- hp_gnt  output  1  host granted.
- hp_rvalid  output  1  host read data valid.
- hp_rdata  output  DW  host read data.
- halt_req  input  1  request freeze of core; level.
- resume  input  1  one-cycle pulse: leave host mode.
- core_frozen  output  1  1 in HOST state; core must hold its pipeline.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset (async, rst_n=0): state=RUN, all rvalid=0, rdata=0, starve_cnt=0, owner=none, core_frozen=0. Outputs mem_en, mem_we and all gnt are 0 while in reset.
- Grants: at most one gnt per cycle, combinational from requests and state. The granted requester's command drives mem_* in the same cycle.
- Requester holds req/addr/wdata until it sees gnt. gnt is the handshake; no further acceptance is needed.
- Read latency: exactly 1 cycle. The owner register captures the granted read; the next cycle, that requester's rvalid=1 and rdata=mem_rdata.
- rdata holds its last value when rvalid=0. Writes produce no rvalid.
- Back-to-back grants are allowed every cycle; the owner pipeline is 1 deep.
- RUN priority: DM > IF > HP, with one exception. If starve_cnt == STARVE_MAX, IF > DM for one grant.
- starve_cnt increments (saturating at STARVE_MAX) when if_req=1 and if_gnt=0, and clears on if_gnt or if_req=0.
- HP in RUN is granted only when DM and IF are both idle.
- FSM:
  - RUN -> DRAIN when halt_req=1. IF is no longer granted from that cycle; DM may still be granted.
  - DRAIN -> HOST when dm_req=0 and no read is outstanding (owner=none).
  - HOST: only HP granted; core_frozen=1; IF and DM gnt=0.
  - HOST -> RUN on resume=1 with halt_req=0. resume while halt_req=1 is ignored.
  - DRAIN -> RUN if halt_req drops before HOST is entered.
- Simultaneous events:
  - A read granted in the last RUN/DRAIN cycle still returns its rvalid, even though the state has changed.
  - When halt_req rises in the same cycle as if_req, that if_req is not granted.
- Address: AW bits, no range check; the full index is used directly.
- Reset mid-read discards the response; no rvalid after reset.

Decomposition:
- Package mips32_mem_pkg:
  - AW/DW defaults.
  - Requester enum {REQ_NONE, REQ_IF, REQ_DM, REQ_HP}.
  - Arbiter state enum {ST_RUN, ST_DRAIN, ST_HOST}.
- One natural sub-module, mips32_mem_prio: combinational priority select from state, requests and starve flag. It returns a one-hot grant.
- FSM, starvation counter, owner register and response routing stay in the top module.

Test Plan:
- Memory preloaded Mem[5]=0x1234; IF reads addr 5 alone -> if_gnt same cycle, if_rvalid=1 with if_rdata=0x00001234 next cycle.
- DM store 0xDEADBEEF to addr 7 and IF read addr 0 in the same cycle -> dm_gnt first, mem_we=1/mem_addr=7; IF granted the following cycle.
- dm_req held high for 6 cycles with if_req high -> IF denied 4 cycles, granted on cycle 5 (starve promotion), starve_cnt back to 0.
- halt_req raised with a DM load outstanding -> DRAIN one cycle, dm_rvalid delivered, HOST entered, core_frozen=1. Host writes 0x0000ABCD to addr 3, then reads addr 3 -> hp_rdata=0x0000ABCD.
- In HOST, pulse resume with halt_req=0 -> RUN next cycle, core_frozen=0, if_req granted. resume with halt_req=1 -> stays HOST.
- Assert rst_n=0 in the cycle after an IF read grant -> no if_rvalid, all outputs at reset values, state RUN after release.

Source files
------------

// File: rtl/mips32_mem_pkg.sv
// Shared types and defaults for the MIPS32 unified-memory arbiter.
// The requester and state encodings are common to the top and the priority selector.
package mips32_mem_pkg;

  localparam int DEF_AW = 10;
  localparam int DEF_DW = 32;

  // Bit positions inside the one-hot grant vector
  localparam int GNT_IF = 0;
  localparam int GNT_DM = 1;
  localparam int GNT_HP = 2;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_IF   = 2'd1,
    REQ_DM   = 2'd2,
    REQ_HP   = 2'd3
  } req_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOST  = 2'd2
  } arb_state_e;

  // Which requester expects read data next cycle, given this cycle's grant.
  function automatic req_e read_owner(input logic [2:0] gnt,
                                      input logic       dm_we,
                                      input logic       hp_we);
    req_e owner;
    if (gnt[GNT_IF]) begin
      owner = REQ_IF;
    end else if (gnt[GNT_DM] && !dm_we) begin
      owner = REQ_DM;
    end else if (gnt[GNT_HP] && !hp_we) begin
      owner = REQ_HP;
    end else begin
      owner = REQ_NONE;
    end
    return owner;
  endfunction

endpackage

// File: rtl/mips32_mem_prio.sv
// Combinational priority select for the unified memory port.
// Produces a one-hot grant {HP, DM, IF} from arbiter state, requests and the starve flag.
module mips32_mem_prio
  import mips32_mem_pkg::*;
(
  input  arb_state_e  state,
  input  logic        en,
  input  logic        if_req,
  input  logic        dm_req,
  input  logic        hp_req,
  input  logic        halt_req,
  input  logic        starve,
  output logic [2:0]  gnt
);

  logic if_ok_s;

  // A fetch arriving together with halt_req is refused so the core can drain.
  assign if_ok_s = if_req && !halt_req;

  always_comb begin
    gnt = 3'b000;
    if (!en) begin
      gnt = 3'b000;
    end else begin
      case (state)
        ST_RUN: begin
          if (if_ok_s && starve) begin
            gnt[GNT_IF] = 1'b1;
          end else if (dm_req) begin
            gnt[GNT_DM] = 1'b1;
          end else if (if_ok_s) begin
            gnt[GNT_IF] = 1'b1;
          end else if (hp_req && !if_req) begin
            gnt[GNT_HP] = 1'b1;
          end else begin
            gnt = 3'b000;
          end
        end
        ST_DRAIN: begin
          if (dm_req) begin
            gnt[GNT_DM] = 1'b1;
          end else begin
            gnt = 3'b000;
          end
        end
        ST_HOST: begin
          if (hp_req) begin
            gnt[GNT_HP] = 1'b1;
          end else begin
            gnt = 3'b000;
          end
        end
        default: begin
          gnt = 3'b000;
        end
      endcase
    end
  end

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-port unified memory arbiter for IF, DM and host requesters with 1-cycle read return.
// Holds the run/drain/host sequencing used to freeze the core while a host loads or inspects memory.
module mips32_mem_arbiter
  import mips32_mem_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  input  logic          hp_req,
  input  logic          hp_we,
  input  logic [AW-1:0] hp_addr,
  input  logic [DW-1:0] hp_wdata,
  output logic          hp_gnt,
  output logic          hp_rvalid,
  output logic [DW-1:0] hp_rdata,
  input  logic          halt_req,
  input  logic          resume,
  output logic          core_frozen,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int             SCW        = $clog2(STARVE_MAX + 1);
  localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

  arb_state_e     state_r;
  req_e           owner_r;
  logic [SCW-1:0] starve_cnt_r;
  logic [DW-1:0]  if_hold_r;
  logic [DW-1:0]  dm_hold_r;
  logic [DW-1:0]  hp_hold_r;
  logic [2:0]     gnt_s;
  logic           starve_s;

  assign starve_s = (starve_cnt_r == STARVE_LIM);

  // Grants are forced low while rst_n is asserted so no access escapes during reset.
  mips32_mem_prio u_prio (
    .state    (state_r),
    .en       (rst_n),
    .if_req   (if_req),
    .dm_req   (dm_req),
    .hp_req   (hp_req),
    .halt_req (halt_req),
    .starve   (starve_s),
    .gnt      (gnt_s)
  );

  assign if_gnt      = gnt_s[GNT_IF];
  assign dm_gnt      = gnt_s[GNT_DM];
  assign hp_gnt      = gnt_s[GNT_HP];
  assign mem_en      = |gnt_s;
  assign core_frozen = (state_r == ST_HOST);

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = {DW{1'b0}};
    if (gnt_s[GNT_DM]) begin
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (gnt_s[GNT_HP]) begin
      mem_we    = hp_we;
      mem_addr  = hp_addr;
      mem_wdata = hp_wdata;
    end else if (gnt_s[GNT_IF]) begin
      mem_we    = 1'b0;
      mem_addr  = if_addr;
      mem_wdata = {DW{1'b0}};
    end else begin
      mem_we    = 1'b0;
      mem_addr  = {AW{1'b0}};
      mem_wdata = {DW{1'b0}};
    end
  end

  // Mode sequencing, read-owner pipeline and fetch starvation tracking.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_RUN;
      owner_r      <= REQ_NONE;
      starve_cnt_r <= {SCW{1'b0}};
    end else begin
      owner_r <= read_owner(gnt_s, dm_we, hp_we);

      if (if_req && !gnt_s[GNT_IF]) begin
        if (!starve_s) begin
          starve_cnt_r <= starve_cnt_r + 1'b1;
        end
      end else begin
        starve_cnt_r <= {SCW{1'b0}};
      end

      case (state_r)
        ST_RUN: begin
          if (halt_req) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!halt_req) begin
            state_r <= ST_RUN;
          end else if (!dm_req && (owner_r == REQ_NONE)) begin
            state_r <= ST_HOST;
          end
        end
        ST_HOST: begin
          if (resume && !halt_req) begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r <= ST_RUN;
        end
      endcase
    end
  end

  // Last delivered word per requester, shown on rdata while rvalid is low.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      if_hold_r <= {DW{1'b0}};
      dm_hold_r <= {DW{1'b0}};
      hp_hold_r <= {DW{1'b0}};
    end else begin
      if (owner_r == REQ_IF) begin
        if_hold_r <= mem_rdata;
      end
      if (owner_r == REQ_DM) begin
        dm_hold_r <= mem_rdata;
      end
      if (owner_r == REQ_HP) begin
        hp_hold_r <= mem_rdata;
      end
    end
  end

  assign if_rvalid = (owner_r == REQ_IF);
  assign dm_rvalid = (owner_r == REQ_DM);
  assign hp_rvalid = (owner_r == REQ_HP);

  assign if_rdata = if_rvalid ? mem_rdata : if_hold_r;
  assign dm_rdata = dm_rvalid ? mem_rdata : dm_hold_r;
  assign hp_rdata = hp_rvalid ? mem_rdata : hp_hold_r;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Scoreboard bench for mips32_mem_arbiter with a behavioural 1024x32 synchronous memory.
module tb_mips32_mem_arbiter;
  import mips32_mem_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk1 = 1'b0;
  logic          rst_n;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          hp_req, hp_we, hp_gnt, hp_rvalid;
  logic [AW-1:0] hp_addr;
  logic [DW-1:0] hp_wdata, hp_rdata;
  logic          halt_req, resume, core_frozen;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = 32'h0000_0000;

  logic [DW-1:0] mem [0:1023];

  typedef struct {
    req_e          who;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk1 = ~clk1;

  mips32_mem_arbiter dut (
    .clk1(clk1), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .hp_req(hp_req), .hp_we(hp_we), .hp_addr(hp_addr), .hp_wdata(hp_wdata),
    .hp_gnt(hp_gnt), .hp_rvalid(hp_rvalid), .hp_rdata(hp_rdata),
    .halt_req(halt_req), .resume(resume), .core_frozen(core_frozen),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory model; a few known words are (re)loaded while reset is held.
  always @(posedge clk1) begin
    if (!rst_n) begin
      mem[0] <= 32'hCAFE_0000;
      mem[5] <= 32'h0000_1234;
      mem[6] <= 32'h0000_6666;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    hp_req = 1'b0; hp_we = 1'b0; hp_addr = '0; hp_wdata = '0;
    halt_req = 1'b0; resume = 1'b0;
  endtask

  task automatic push_exp(input req_e who, input logic [DW-1:0] data);
    exp_t e;
    e.who  = who;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 4 && sb_q.size() != 0; i++) begin
      @(negedge clk1);
      #1;
    end
    check_eq(tag, 32'(sb_q.size()), 32'd0);
  endtask

  // Response monitor: every rvalid must match the oldest expected read.
  always @(negedge clk1) begin
    int            nv;
    exp_t          e;
    req_e          who;
    logic [DW-1:0] data;
    nv = int'(if_rvalid) + int'(dm_rvalid) + int'(hp_rvalid);
    if (nv != 0) begin
      check_eq("rvalid_onehot", 32'(nv), 32'd1);
      if (if_rvalid)      begin who = REQ_IF; data = if_rdata; end
      else if (dm_rvalid) begin who = REQ_DM; data = dm_rdata; end
      else                begin who = REQ_HP; data = hp_rdata; end
      if (sb_q.size() == 0) begin
        check_eq("rvalid_unexpected", 32'(who), 32'(REQ_NONE));
      end else begin
        e = sb_q.pop_front();
        check_eq("rvalid_owner", 32'(who), 32'(e.who));
        check_eq("rdata", data, e.data);
      end
    end
  end

  initial begin
    idle();
    rst_n  = 1'b0;
    if_req = 1'b1; dm_req = 1'b1; hp_req = 1'b1;
    @(negedge clk1);
    check_eq("rst_gnt", 32'({if_gnt, dm_gnt, hp_gnt}), 32'd0);
    check_eq("rst_mem_en", 32'(mem_en), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_frozen", 32'(core_frozen), 32'd0);
    check_eq("rst_rvalid", 32'({if_rvalid, dm_rvalid, hp_rvalid}), 32'd0);
    check_eq("rst_rdata", if_rdata | dm_rdata | hp_rdata, 32'd0);
    nxt();
    rst_n = 1'b1;
    idle();

    // IF read alone
    if_req = 1'b1; if_addr = 10'd5;
    @(negedge clk1);
    check_eq("t1_if_gnt", 32'(if_gnt), 32'd1);
    check_eq("t1_mem", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, 10'd5}));
    push_exp(REQ_IF, 32'h0000_1234);
    nxt();
    idle();
    wait_drain("t1_drain");

    // DM store beats IF fetch
    nxt();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd7; dm_wdata = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 10'd0;
    @(negedge clk1);
    check_eq("t2_gnt", 32'({hp_gnt, dm_gnt, if_gnt}), 32'b010);
    check_eq("t2_mem", 32'({mem_we, mem_addr}), 32'({1'b1, 10'd7}));
    check_eq("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
    nxt();
    dm_req = 1'b0;
    @(negedge clk1);
    check_eq("t2_if_gnt", 32'({hp_gnt, dm_gnt, if_gnt}), 32'b001);
    check_eq("t2_if_addr", 32'(mem_addr), 32'd0);
    push_exp(REQ_IF, 32'hCAFE_0000);
    nxt();
    idle();
    wait_drain("t2_drain");

    // HP in RUN only when DM and IF are idle; also reads back the DM store
    nxt();
    hp_req = 1'b1; hp_we = 1'b0; hp_addr = 10'd7;
    if_req = 1'b1; if_addr = 10'd0;
    @(negedge clk1);
    check_eq("t7_gnt_if", 32'({hp_gnt, dm_gnt, if_gnt}), 32'b001);
    push_exp(REQ_IF, 32'hCAFE_0000);
    nxt();
    if_req = 1'b0;
    @(negedge clk1);
    check_eq("t7_gnt_hp", 32'({hp_gnt, dm_gnt, if_gnt}), 32'b100);
    push_exp(REQ_HP, 32'hDEAD_BEEF);
    nxt();
    idle();
    wait_drain("t7_drain");

    // Starvation promotion
    nxt();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd20; dm_wdata = 32'h2020_2020;
    if_req = 1'b1; if_addr = 10'd5;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk1);
      check_eq("t3_denied", 32'({hp_gnt, dm_gnt, if_gnt}), 32'b010);
      nxt();
    end
    @(negedge clk1);
    check_eq("t3_promoted", 32'({hp_gnt, dm_gnt, if_gnt}), 32'b001);
    push_exp(REQ_IF, 32'h0000_1234);
    nxt();
    if_addr = 10'd6;
    @(negedge clk1);
    check_eq("t3_cnt_cleared", 32'({hp_gnt, dm_gnt, if_gnt}), 32'b010);
    nxt();
    dm_req = 1'b0;
    @(negedge clk1);
    check_eq("t3_if_after", 32'({hp_gnt, dm_gnt, if_gnt}), 32'b001);
    push_exp(REQ_IF, 32'h0000_6666);
    nxt();
    idle();
    wait_drain("t3_drain");

    // Halt with a DM load outstanding, then host write/read
    nxt();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd7;
    @(negedge clk1);
    check_eq("t4_dm_load", 32'({hp_gnt, dm_gnt, if_gnt}), 32'b010);
    push_exp(REQ_DM, 32'hDEAD_BEEF);
    nxt();
    dm_req = 1'b0; halt_req = 1'b1; if_req = 1'b1; if_addr = 10'd5;
    @(negedge clk1);
    check_eq("t4_halt_if_blocked", 32'({mem_en, if_gnt}), 32'd0);
    check_eq("t4_not_frozen_yet", 32'(core_frozen), 32'd0);
    nxt();
    @(negedge clk1);
    check_eq("t4_drain", 32'({core_frozen, if_gnt}), 32'd0);
    check_eq("t4_dm_delivered", 32'(sb_q.size()), 32'd0);
    nxt();
    hp_req = 1'b1; hp_we = 1'b1; hp_addr = 10'd3; hp_wdata = 32'h0000_ABCD;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd9; dm_wdata = 32'h9999_9999;
    @(negedge clk1);
    check_eq("t4_host_frozen", 32'(core_frozen), 32'd1);
    check_eq("t4_host_gnt", 32'({hp_gnt, dm_gnt, if_gnt}), 32'b100);
    check_eq("t4_host_mem", 32'({mem_we, mem_addr}), 32'({1'b1, 10'd3}));
    check_eq("t4_host_wdata", mem_wdata, 32'h0000_ABCD);
    nxt();
    hp_we = 1'b0;
    @(negedge clk1);
    check_eq("t4_host_rd_gnt", 32'({hp_gnt, dm_gnt, if_gnt, mem_we}), 32'b1000);
    push_exp(REQ_HP, 32'h0000_ABCD);
    nxt();
    hp_req = 1'b0; dm_req = 1'b0; if_req = 1'b0;
    wait_drain("t4_drain");

    // Resume ignored while halt_req is high, honoured once it drops
    nxt();
    resume = 1'b1;
    @(negedge clk1);
    check_eq("t5_frozen_a", 32'(core_frozen), 32'd1);
    nxt();
    halt_req = 1'b0; if_req = 1'b1; if_addr = 10'd6;
    @(negedge clk1);
    check_eq("t5_still_host", 32'({core_frozen, if_gnt}), 32'b10);
    nxt();
    resume = 1'b0;
    @(negedge clk1);
    check_eq("t5_run", 32'({core_frozen, if_gnt}), 32'b01);
    check_eq("t5_addr", 32'(mem_addr), 32'd6);
    push_exp(REQ_IF, 32'h0000_6666);
    nxt();
    idle();
    wait_drain("t5_drain");

    // Reset in the cycle after an IF read grant discards the response
    nxt();
    if_req = 1'b1; if_addr = 10'd5;
    @(negedge clk1);
    check_eq("t6_if_gnt", 32'(if_gnt), 32'd1);
    nxt();
    rst_n = 1'b0;
    @(negedge clk1);
    check_eq("t6_rvalid", 32'({if_rvalid, dm_rvalid, hp_rvalid}), 32'd0);
    check_eq("t6_rdata", if_rdata | dm_rdata | hp_rdata, 32'd0);
    check_eq("t6_outs", 32'({if_gnt, dm_gnt, hp_gnt, mem_en, mem_we, core_frozen}), 32'd0);
    nxt();
    rst_n = 1'b1;
    @(negedge clk1);
    check_eq("t6_run_after", 32'({core_frozen, if_gnt}), 32'b01);
    push_exp(REQ_IF, 32'h0000_1234);
    nxt();
    idle();
    wait_drain("t6_drain");

    nxt();
    nxt();
    check_eq("sb_final_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
